// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl
//   Sequencer/arbiter in front of a multi-port register file (2 read, 1 write).
//   After reset it sweeps every register to INIT_VAL through the write port,
//   then passes core writeback straight through and shares the write port and
//   read port 2 with a debug requester via a stall/ack handshake.
//
// Ports
//   clk, rst                      clock; synchronous active-high reset
//   core_we/core_waddr/core_wdata core writeback request
//   core_a2                       core read-port-2 address
//   core_stall                    core must hold its state and inputs
//   init_done                     high once the init sweep has completed
//   dbg_req/dbg_we/dbg_addr/dbg_wdata  debug access request (level, held to ack)
//   dbg_ack                       one-cycle completion pulse
//   dbg_rdata                     registered debug read data
//   rf_we3/rf_a3/rf_wd3           register-file write port
//   rf_a2/rf_rd2                  register-file read port 2 (rd2 combinational)
module regfile_access_ctrl #(
  parameter int unsigned    NREGS        = 32,
  parameter int unsigned    DW           = 32,
  parameter logic [DW-1:0]  INIT_VAL     = '0,
  parameter bit             X0_HARDWIRED = 1'b1,
  localparam int unsigned   AW           = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_we,
  input  logic [AW-1:0] core_waddr,
  input  logic [DW-1:0] core_wdata,
  input  logic [AW-1:0] core_a2,
  output logic          core_stall,
  output logic          init_done,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  output logic          rf_we3,
  output logic [AW-1:0] rf_a3,
  output logic [DW-1:0] rf_wd3,
  output logic [AW-1:0] rf_a2,
  input  logic [DW-1:0] rf_rd2
);

  typedef enum logic [1:0] {StInit, StRun, StDbg, StAck} state_e;

  state_e        state_q;
  logic [AW-1:0] cnt_q;

  logic core_wr_ok;
  logic dbg_wr_ok;

  // Address 0 is read-only for both requesters once the init sweep is done.
  assign core_wr_ok = core_we & ~(X0_HARDWIRED & (core_waddr == '0));
  assign dbg_wr_ok  = dbg_we  & ~(X0_HARDWIRED & (dbg_addr == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StInit;
      cnt_q     <= '0;
      dbg_ack   <= 1'b0;
      dbg_rdata <= '0;
      init_done <= 1'b0;
    end else begin
      dbg_ack <= 1'b0;
      case (state_q)
        StInit: begin
          cnt_q <= cnt_q + AW'(1);
          if (cnt_q == AW'(NREGS - 1)) begin
            state_q   <= StRun;
            init_done <= 1'b1;
          end
        end
        StRun: begin
          if (dbg_req) state_q <= StDbg;
        end
        StDbg: begin
          if (!dbg_we) dbg_rdata <= rf_rd2;
          dbg_ack <= 1'b1;
          state_q <= StAck;
        end
        StAck: begin
          // dbg_req deliberately not sampled here; a held request restarts from RUN.
          state_q <= StRun;
        end
        default: state_q <= StInit;
      endcase
    end
  end

  always_comb begin
    core_stall = 1'b0;
    rf_we3     = core_wr_ok;
    rf_a3      = core_waddr;
    rf_wd3     = core_wdata;
    rf_a2      = core_a2;
    case (state_q)
      StInit: begin
        core_stall = 1'b1;
        rf_we3     = 1'b1;
        rf_a3      = cnt_q;
        rf_wd3     = INIT_VAL;
      end
      StDbg: begin
        core_stall = 1'b1;
        rf_we3     = dbg_wr_ok;
        rf_a3      = dbg_addr;
        rf_wd3     = dbg_wdata;
        if (!dbg_we) rf_a2 = dbg_addr;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
module tb_regfile_access_ctrl;

  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_we;
  logic [AW-1:0] core_waddr;
  logic [DW-1:0] core_wdata;
  logic [AW-1:0] core_a2;
  logic          core_stall;
  logic          init_done;
  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_ack;
  logic [DW-1:0] dbg_rdata;
  logic          rf_we3;
  logic [AW-1:0] rf_a3;
  logic [DW-1:0] rf_wd3;
  logic [AW-1:0] rf_a2;
  logic [DW-1:0] rf_rd2;

  always #5 clk = ~clk;

  regfile_access_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .core_we    (core_we),
    .core_waddr (core_waddr),
    .core_wdata (core_wdata),
    .core_a2    (core_a2),
    .core_stall (core_stall),
    .init_done  (init_done),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_ack    (dbg_ack),
    .dbg_rdata  (dbg_rdata),
    .rf_we3     (rf_we3),
    .rf_a3      (rf_a3),
    .rf_wd3     (rf_wd3),
    .rf_a2      (rf_a2),
    .rf_rd2     (rf_rd2)
  );

  // Register file the controller drives; combinational read port 2.
  logic [DW-1:0] tb_rf [NREGS];
  always @(posedge clk) if (rf_we3) tb_rf[rf_a3] <= rf_wd3;
  assign rf_rd2 = tb_rf[rf_a2];

  // Reference view: architectural register contents and last debug read.
  logic [DW-1:0] ref_regs [NREGS];
  logic [DW-1:0] exp_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got,
                          input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic bit writes(input bit we, input logic [AW-1:0] addr);
    return we && (addr != 0);
  endfunction

  task automatic rand_core();
    core_we    = 1'($urandom_range(0, 1));
    core_waddr = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
    core_wdata = $urandom;
    core_a2    = AW'($urandom);
  endtask

  // Outputs expected whenever the core owns the ports (RUN and ACK cycles).
  task automatic check_core_path(input string tag);
    check_eq({tag, "_stall"}, DW'(core_stall), 0);
    check_eq({tag, "_we3"}, DW'(rf_we3), DW'(writes(core_we, core_waddr)));
    check_eq({tag, "_a3"}, DW'(rf_a3), DW'(core_waddr));
    check_eq({tag, "_wd3"}, rf_wd3, core_wdata);
    check_eq({tag, "_a2"}, DW'(rf_a2), DW'(core_a2));
    if (writes(core_we, core_waddr)) ref_regs[core_waddr] = core_wdata;
  endtask

  task automatic core_cycle(input bit we, input logic [AW-1:0] waddr,
                            input logic [DW-1:0] wdata, input logic [AW-1:0] a2);
    core_we = we; core_waddr = waddr; core_wdata = wdata; core_a2 = a2;
    dbg_req = 1'b0;
    @(negedge clk);
    check_eq("run_ack", DW'(dbg_ack), 0);
    check_eq("run_init_done", DW'(init_done), 1);
    check_eq("run_rdata_hold", dbg_rdata, exp_rdata);
    check_core_path("run");
    next_cycle();
  endtask

  // Reset has just been taken; checks the full sweep and the first RUN cycle.
  task automatic check_init();
    for (int i = 0; i < NREGS; i++) begin
      rand_core();
      dbg_req   = 1'($urandom_range(0, 1));
      dbg_we    = 1'($urandom_range(0, 1));
      dbg_addr  = AW'($urandom);
      dbg_wdata = $urandom;
      @(negedge clk);
      check_eq("init_stall", DW'(core_stall), 1);
      check_eq("init_we3", DW'(rf_we3), 1);
      check_eq("init_a3", DW'(rf_a3), DW'(i));
      check_eq("init_wd3", rf_wd3, 0);
      check_eq("init_done_low", DW'(init_done), 0);
      check_eq("init_ack", DW'(dbg_ack), 0);
      check_eq("init_rdata", dbg_rdata, 0);
      next_cycle();
    end
    for (int r = 0; r < NREGS; r++) ref_regs[r] = '0;
    exp_rdata = '0;
    core_cycle(1'b0, '0, '0, AW'($urandom));
  endtask

  task automatic dbg_access(input bit we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input bit keep);
    logic [DW-1:0] rd_exp;
    // Request cycle (RUN): core write in the same cycle still lands.
    rand_core();
    dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
    @(negedge clk);
    check_eq("req_ack", DW'(dbg_ack), 0);
    check_core_path("req");
    next_cycle();
    // Access cycle: core stalled and its write suppressed.
    rand_core();
    core_we = 1'b1;
    @(negedge clk);
    check_eq("dbg_stall", DW'(core_stall), 1);
    check_eq("dbg_ack_early", DW'(dbg_ack), 0);
    check_eq("dbg_we3", DW'(rf_we3), DW'(writes(we, addr)));
    if (we) begin
      check_eq("dbg_a3", DW'(rf_a3), DW'(addr));
      check_eq("dbg_wd3", rf_wd3, wdata);
      if (writes(we, addr)) ref_regs[addr] = wdata;
    end else begin
      check_eq("dbg_a2", DW'(rf_a2), DW'(addr));
      rd_exp    = ref_regs[addr];
      exp_rdata = rd_exp;
    end
    next_cycle();
    // Ack cycle: core owns the ports again.
    rand_core();
    dbg_req = keep;
    @(negedge clk);
    check_eq("ack_pulse", DW'(dbg_ack), 1);
    check_eq("ack_rdata", dbg_rdata, exp_rdata);
    check_core_path("ack");
    next_cycle();
  endtask

  task automatic reset_in_dbg();
    rand_core();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    check_core_path("rreq");
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check_eq("rdbg_stall", DW'(core_stall), 1);
    next_cycle();
    rst = 1'b0;
    check_init();
  endtask

  initial begin
    bit chain;
    rst = 1'b1; core_we = 0; core_waddr = '0; core_wdata = '0; core_a2 = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    exp_rdata = '0;
    for (int r = 0; r < NREGS; r++) ref_regs[r] = '0;
    repeat (2) next_cycle();
    rst = 1'b0;
    check_init();

    core_cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd3);
    core_cycle(1'b1, 5'd0, 32'h1111_2222, 5'd5);
    dbg_access(1'b1, 5'd7, 32'h0000_1234, 1'b0);
    dbg_access(1'b0, 5'd7, '0, 1'b0);
    dbg_access(1'b0, 5'd5, '0, 1'b1);      // held request restarts an access
    dbg_access(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
    dbg_access(1'b0, 5'd0, '0, 1'b0);
    core_cycle(1'b0, 5'd1, '0, 5'd7);

    chain = 1'b0;
    for (int it = 0; it < 200; it++) begin
      if (chain || $urandom_range(0, 2) == 0) begin
        chain = ($urandom_range(0, 3) == 0);
        dbg_access(1'($urandom_range(0, 1)),
                   ($urandom_range(0, 5) == 0) ? '0 : AW'($urandom), $urandom, chain);
      end else begin
        core_cycle(1'($urandom_range(0, 1)),
                   ($urandom_range(0, 4) == 0) ? '0 : AW'($urandom), $urandom,
                   AW'($urandom));
      end
    end

    reset_in_dbg();
    dbg_access(1'b0, 5'd5, '0, 1'b0);
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 0)
        dbg_access(1'($urandom_range(0, 1)), AW'($urandom), $urandom, 1'b0);
      else
        core_cycle(1'b1, AW'($urandom), $urandom, AW'($urandom));
    end

    @(negedge clk);
    for (int r = 0; r < NREGS; r++) check_eq($sformatf("rf_final_%0d", r), tb_rf[r], ref_regs[r]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
